// File: rtl/irq_stim_ctrl.sv
// Fixed-priority interrupt controller: latches edge/level sources as pending and
// claims one at a time toward the core, with an ack handshake, holdoff gap and ack timeout.
module irq_stim_ctrl #(
   parameter int                   NUM_SRC     = 16,
   parameter int                   ID_W        = 4,
   parameter logic [NUM_SRC-1:0]   EDGE_MASK   = {NUM_SRC{1'b1}},
   parameter int                   HOLDOFF     = 2,
   parameter int                   ACK_TIMEOUT = 1024
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic [NUM_SRC-1:0]  src_i,
   input  logic [NUM_SRC-1:0]  en_i,
   input  logic                ack_i,
   output logic                meip_o,
   output logic [ID_W-1:0]     claim_id_o,
   output logic [NUM_SRC-1:0]  pending_o,
   output logic                timeout_o
);

   localparam int TMO_W  = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
   localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

   state_t               r_state;
   logic [NUM_SRC-1:0]   r_src_q;
   logic [NUM_SRC-1:0]   r_pending;
   logic                 r_meip;
   logic [ID_W-1:0]      r_claim_id;
   logic                 r_timeout;
   logic [TMO_W-1:0]     r_tmo_cnt;
   logic [HOLD_W-1:0]    r_hold_cnt;

   logic [NUM_SRC-1:0]   w_set;
   logic [NUM_SRC-1:0]   w_clr;
   logic [NUM_SRC-1:0]   w_elig;
   logic [ID_W-1:0]      w_winner;
   logic                 w_ack_ok;

   assign w_ack_ok = (r_state == S_WAIT) && ack_i;
   assign w_set    = (EDGE_MASK & src_i & ~r_src_q) | (~EDGE_MASK & src_i);
   assign w_clr    = w_ack_ok ? (NUM_SRC'(1) << r_claim_id) : '0;
   assign w_elig   = r_pending & en_i;

   // Lowest index wins: scan downward so the last hit is the smallest index
   always_comb begin
      w_winner = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (w_elig[i]) w_winner = ID_W'(i);
      end
   end

   // Edge bits let a fresh edge beat the clear; level bits let the clear win
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_src_q   <= '0;
         r_pending <= '0;
      end else begin
         r_src_q   <= src_i;
         r_pending <= (r_pending & ~w_clr) | (w_set & (EDGE_MASK | ~w_clr));
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state    <= S_IDLE;
         r_meip     <= 1'b0;
         r_claim_id <= '0;
         r_timeout  <= 1'b0;
         r_tmo_cnt  <= '0;
         r_hold_cnt <= '0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_elig != '0) begin
                  r_state    <= S_WAIT;
                  r_meip     <= 1'b1;
                  r_claim_id <= w_winner;
                  r_tmo_cnt  <= '0;
               end
            end
            S_WAIT: begin
               if (ack_i) begin
                  r_meip     <= 1'b0;
                  r_hold_cnt <= '0;
                  r_state    <= S_HOLD;
               end else if (ACK_TIMEOUT != 0) begin
                  if (r_tmo_cnt == TMO_LAST) begin
                     r_timeout  <= 1'b1;
                     r_meip     <= 1'b0;
                     r_hold_cnt <= '0;
                     r_state    <= S_HOLD;
                  end else begin
                     r_tmo_cnt <= r_tmo_cnt + 1'b1;
                  end
               end
            end
            S_HOLD: begin
               if (r_hold_cnt == HOLD_LAST) begin
                  r_state <= S_IDLE;
               end else begin
                  r_hold_cnt <= r_hold_cnt + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign meip_o     = r_meip;
   assign claim_id_o = r_claim_id;
   assign pending_o  = r_pending;
   assign timeout_o  = r_timeout;

endmodule

// File: tb/tb_irq_stim_ctrl.sv
// Scoreboard bench for irq_stim_ctrl: expected claim IDs are queued as sources are
// driven and popped on each rising edge of meip_o.
module tb_irq_stim_ctrl;

   localparam int              NUM_SRC = 16;
   localparam int              ID_W    = 4;
   localparam logic [15:0]     EMASK   = 16'hFFFE;
   localparam int              HOLDOFF = 2;
   localparam int              ATMO    = 8;

   logic                clk;
   logic                rst;
   logic [NUM_SRC-1:0]  src;
   logic [NUM_SRC-1:0]  en;
   logic                ack;
   logic                meip;
   logic [ID_W-1:0]     claim_id;
   logic [NUM_SRC-1:0]  pending;
   logic                tmo;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_q[$];
   logic meip_prev = 1'b0;

   irq_stim_ctrl #(
      .NUM_SRC(NUM_SRC), .ID_W(ID_W), .EDGE_MASK(EMASK),
      .HOLDOFF(HOLDOFF), .ACK_TIMEOUT(ATMO)
   ) dut (
      .clk_i(clk), .reset_i(rst), .src_i(src), .en_i(en), .ack_i(ack),
      .meip_o(meip), .claim_id_o(claim_id), .pending_o(pending), .timeout_o(tmo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: every new claim must match the oldest queued expectation
   always @(negedge clk) begin
      if (meip && !meip_prev) begin
         if (exp_q.size() == 0) check("unexpected_claim", {28'd0, claim_id}, 32'hFFFF_FFFF);
         else check("claim_id", {28'd0, claim_id}, exp_q.pop_front());
      end
      meip_prev = meip;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_meip(input string tag);
      int n = 0;
      while (!meip && n < 40) begin
         tick();
         n++;
      end
      if (!meip) check(tag, 32'd0, 32'd1);
   endtask

   task automatic do_ack();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("ack_drop", {31'd0, meip}, 32'd0);
   endtask

   task automatic gap_check(input string tag);
      int n = 0;
      while (!meip && n < 40) begin
         tick();
         n++;
      end
      check(tag, n, HOLDOFF + 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1; src = '0; en = '1; ack = 1'b0;
      repeat (3) tick();
      check("rst_meip", {31'd0, meip}, 32'd0);
      check("rst_claim", {28'd0, claim_id}, 32'd0);
      check("rst_pending", {16'd0, pending}, 32'd0);
      check("rst_tmo", {31'd0, tmo}, 32'd0);
      rst = 1'b0;
      repeat (5) tick();

      // Single edge pulse on source 5
      exp_q.push_back(5);
      src[5] = 1'b1;
      tick();
      src = '0;
      check("t1_pend", {16'd0, pending}, 32'h0020);
      check("t1_meip_early", {31'd0, meip}, 32'd0);
      tick();
      check("t1_meip", {31'd0, meip}, 32'd1);
      check("t1_claim", {28'd0, claim_id}, 32'd5);
      do_ack();
      check("t1_pend_clr", {16'd0, pending}, 32'd0);
      repeat (4) tick();

      // Simultaneous edges on 3 and 9
      exp_q.push_back(3); exp_q.push_back(9);
      src[3] = 1'b1; src[9] = 1'b1;
      tick();
      src = '0;
      wait_meip("t2_wait_a");
      repeat (3) tick();
      do_ack();
      gap_check("t2_gap");
      check("t2_claim9", {28'd0, claim_id}, 32'd9);
      repeat (3) tick();
      do_ack();
      check("t2_pend_zero", {16'd0, pending}, 32'd0);
      repeat (4) tick();

      // Level source 0: re-claimed while high, sticky until acked
      exp_q.push_back(0); exp_q.push_back(0);
      src[0] = 1'b1;
      tick();
      check("t3_pend", {16'd0, pending}, 32'h0001);
      wait_meip("t3_wait");
      do_ack();
      gap_check("t3_gap");
      src[0] = 1'b0;
      repeat (2) tick();
      check("t3_sticky", {16'd0, pending}, 32'h0001);
      do_ack();
      repeat (6) tick();
      check("t3_no_third", {31'd0, meip}, 32'd0);
      check("t3_pend_zero", {16'd0, pending}, 32'd0);

      // Ack timeout on source 7, then re-claim
      exp_q.push_back(7); exp_q.push_back(7);
      src[7] = 1'b1;
      tick();
      src = '0;
      wait_meip("t4_wait");
      n = 0;
      do begin
         tick();
         n++;
      end while (!tmo && n < 20);
      check("t4_tmo_cycles", n, ATMO);
      check("t4_meip_drop", {31'd0, meip}, 32'd0);
      check("t4_pend_kept", {16'd0, pending}, 32'h0080);
      tick();
      check("t4_tmo_pulse", {31'd0, tmo}, 32'd0);
      wait_meip("t4_reclaim");
      do_ack();
      repeat (4) tick();

      // Edge source 2 re-rises in the ack cycle
      exp_q.push_back(2); exp_q.push_back(2);
      src[2] = 1'b1;
      tick();
      src = '0;
      wait_meip("t5_wait");
      src[2] = 1'b1; ack = 1'b1;
      tick();
      src = '0; ack = 1'b0;
      check("t5_pend_kept", {16'd0, pending}, 32'h0004);
      wait_meip("t5_second");
      do_ack();
      repeat (4) tick();
      check("t5_pend_zero", {16'd0, pending}, 32'd0);

      // Disabled source stays pending; enable claims it; reset mid-WAIT
      en = ~16'h0010;
      src[4] = 1'b1;
      tick();
      src = '0;
      repeat (3) tick();
      check("t6_pend", {16'd0, pending}, 32'h0010);
      check("t6_no_meip", {31'd0, meip}, 32'd0);
      exp_q.push_back(4);
      en = '1;
      tick();
      check("t6_meip", {31'd0, meip}, 32'd1);
      check("t6_claim", {28'd0, claim_id}, 32'd4);
      en = '0;
      tick();
      check("t6_claim_kept", {31'd0, meip}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("t6_rst_meip", {31'd0, meip}, 32'd0);
      check("t6_rst_claim", {28'd0, claim_id}, 32'd0);
      check("t6_rst_pend", {16'd0, pending}, 32'd0);
      check("t6_rst_tmo", {31'd0, tmo}, 32'd0);
      tick();
      rst = 1'b0;
      en = '1;
      repeat (3) tick();

      check("sb_empty", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
